shr_seq: RTL and testbench

- Sequential logical shift-right unit; the right-shift counterpart of the team's combinational SHL datapath block.
- Shifts one bit position per clock so that a wide operand never needs a full barrel shifter.
- Uses valid/ready handshakes on both input and output, so it drops into the pipelined datapath between registers.
- One operation in flight at a time.

---
 rtl/shr_pkg.sv | 22 ++
 rtl/shr_step_cnt.sv | 26 ++
 rtl/shr_seq.sv | 100 ++++++++++
 tb/tb_shr_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shr_pkg.sv
// Shared definitions for the sequential shift-right unit: state encodings and shift-count clamp.
package shr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT,
        StDone  = ST_DONE
    } state_e;

    // Compares the full-width amount, so any upper bit set selects the clamp.
    function automatic int unsigned clamp_amt(input logic [63:0] amt, input int unsigned width);
        if (amt >= 64'(width)) begin
            return width;
        end
        return amt[31:0];
    endfunction

endpackage

// File: rtl/shr_step_cnt.sv
// Loadable down-counter tracking the remaining single-bit shift steps.
module shr_step_cnt #(
    parameter int unsigned CNTW = 5
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    input  logic            dec,
    output logic [CNTW-1:0] cnt,
    output logic            zero
);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNTW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/shr_seq.sv
// Sequential shift-right unit, one bit per clock, valid/ready on both sides.
// Define SHR_ARITH_EN for arithmetic shift (sign fill captured at accept); logical otherwise.
module shr_seq
    import shr_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16,
    localparam int unsigned CNTW = $clog2(DATAWIDTH + 1)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_e                state_q, state_d;
    logic [DATAWIDTH-1:0]  sreg_q, sreg_d;
    logic                  load, dec, zero, fill;
    logic [CNTW-1:0]       load_val;
    logic [CNTW-1:0]       unused_cnt;

    assign load_val = CNTW'(clamp_amt(64'(sh_amt), DATAWIDTH));

`ifdef SHR_ARITH_EN
    logic fill_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fill_q <= 1'b0;
        end else if (load) begin
            fill_q <= a[DATAWIDTH-1];
        end
    end

    assign fill = fill_q;
`else
    assign fill = 1'b0;
`endif

    shr_step_cnt #(
        .CNTW(CNTW)
    ) u_cnt (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .cnt      (unused_cnt),
        .zero     (zero)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        load    = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sreg_d  = a;
                    load    = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (zero) begin
                    state_d = StDone;
                end else begin
                    sreg_d = {fill, sreg_q[DATAWIDTH-1:1]};
                    dec    = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign d         = sreg_q;

endmodule

// File: tb/tb_shr_seq.sv
// Self-checking bench for shr_seq: directed vector table, reset corner sequences, random ops.
module tb_shr_seq;
    import shr_pkg::*;

    localparam int unsigned DW = 16;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] sh_amt = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] d;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    shr_seq #(
        .DATAWIDTH(DW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .a         (a),
        .sh_amt    (sh_amt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] amt;
        int          hold;
        logic [15:0] exp_log;
        logic [15:0] exp_ari;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain shift operators on the clamped amount.
    function automatic logic [15:0] model(input logic [15:0] av, input logic [15:0] amt);
        int n;
        n = (amt > 16'd16) ? 16 : int'(amt);
`ifdef SHR_ARITH_EN
        return 16'($signed(av) >>> n);
`else
        return av >> n;
`endif
    endfunction

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_op(input logic [15:0] av, input logic [15:0] amt, input int hold,
                         input logic [15:0] exp, input string name);
        int n;
        int cyc;
        n = (amt > 16'd16) ? 16 : int'(amt);
        chk({name, " in_ready idle"}, 16'(in_ready), 16'd1);
        chk({name, " state enc"}, 16'(dut.state_q == ST_IDLE), 16'd1);
        a = av;
        sh_amt = amt;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        a = 16'($urandom);
        sh_amt = 16'($urandom);
        chk({name, " in_ready busy"}, 16'(in_ready), 16'd0);
        wait_valid(cyc);
        chk({name, " latency"}, 16'(cyc), 16'(n + 1));
        chk({name, " d"}, d, exp);
        chk({name, " in_ready done"}, 16'(in_ready), 16'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            chk({name, " stall d"}, d, exp);
            chk({name, " stall valid"}, 16'(out_valid), 16'd1);
            chk({name, " stall in_ready"}, 16'(in_ready), 16'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, " consumed valid"}, 16'(out_valid), 16'd0);
        chk({name, " consumed in_ready"}, 16'(in_ready), 16'd1);
    endtask

    vec_t vecs[9];

    initial begin
        int cyc;
        logic [15:0] ra, ramt;
        logic [15:0] e;

        vecs[0] = '{16'hF00F, 16'd4,     0, 16'h0F00, 16'hFF00};
        vecs[1] = '{16'h1234, 16'd0,     0, 16'h1234, 16'h1234};
        vecs[2] = '{16'hFFFF, 16'd20,    0, 16'h0000, 16'hFFFF};
        vecs[3] = '{16'hFFFF, 16'h8001,  0, 16'h0000, 16'hFFFF};
        vecs[4] = '{16'h00F0, 16'd4,     3, 16'h000F, 16'h000F};
        vecs[5] = '{16'h8000, 16'd3,     0, 16'h1000, 16'hF000};
        vecs[6] = '{16'h8000, 16'd16,    1, 16'h0000, 16'hFFFF};
        vecs[7] = '{16'h8000, 16'd15,    0, 16'h0001, 16'hFFFF};
        vecs[8] = '{16'h7FFF, 16'd1,     0, 16'h3FFF, 16'h3FFF};

        step();
        step();
        chk("reset d", d, 16'h0000);
        chk("reset out_valid", 16'(out_valid), 16'd0);
        chk("reset in_ready", 16'(in_ready), 16'd1);
        Rst = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
`ifdef SHR_ARITH_EN
            e = vecs[i].exp_ari;
`else
            e = vecs[i].exp_log;
`endif
            do_op(vecs[i].a, vecs[i].amt, vecs[i].hold, e, $sformatf("vec%0d", i));
        end

        // Reset on the 3rd SHIFT edge discards the partial result.
        a = 16'hAAAA;
        sh_amt = 16'd8;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        Rst = 1'b0;
        step();
        chk("midrst d", d, 16'h0000);
        chk("midrst out_valid", 16'(out_valid), 16'd0);
        chk("midrst in_ready", 16'(in_ready), 16'd1);
        Rst = 1'b1;
`ifdef SHR_ARITH_EN
        do_op(16'h8000, 16'd15, 0, 16'hFFFF, "after_rst");
`else
        do_op(16'h8000, 16'd15, 0, 16'h0001, "after_rst");
`endif

        // Reset beats out_ready in DONE.
        a = 16'h00F0;
        sh_amt = 16'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("donerst latency", 16'(cyc), 16'd2);
        Rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("donerst d", d, 16'h0000);
        chk("donerst out_valid", 16'(out_valid), 16'd0);
        chk("donerst in_ready", 16'(in_ready), 16'd1);
        out_ready = 1'b0;

        // Reset beats in_valid: nothing is accepted.
        a = 16'h1111;
        sh_amt = 16'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        Rst = 1'b1;
        step();
        chk("rstvalid in_ready", 16'(in_ready), 16'd1);
        chk("rstvalid d", d, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            ramt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
            do_op(ra, ramt, int'($urandom_range(0, 2)), model(ra, ramt), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
